// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with occupancy count, watermarks and sticky error flags.
// Define FIFO_PARAM_REGOUT_EN for a registered q (one-cycle read latency) instead of show-ahead.
module fifo_param #(
  parameter int WIDTH    = 8,
  parameter int ADDR_W   = 4,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 2
) (
  input  logic              clock,
  input  logic              sclr,
  input  logic              wrreq,
  input  logic [WIDTH-1:0]  data,
  input  logic              rdreq,
  output logic [WIDTH-1:0]  q,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   usedw,
  output logic              overflow,
  output logic              underflow,
  input  logic              err_clr
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] AF_L = (ADDR_W + 1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_L = (ADDR_W + 1)'(AE_LEVEL);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_W:0]  r_wp;
  logic [ADDR_W:0]  r_rp;
  logic             r_ovf;
  logic             r_udf;

  logic [ADDR_W:0]  w_usedw;
  logic             w_full;
  logic             w_empty;
  logic             w_wr_ok;
  logic             w_rd_ok;

  // Status is decoded from the registered pointers only, never from the requests.
  assign w_usedw = r_wp - r_rp;
  assign w_empty = (r_wp == r_rp);
  assign w_full  = (r_wp[ADDR_W-1:0] == r_rp[ADDR_W-1:0]) && (r_wp[ADDR_W] != r_rp[ADDR_W]);
  assign w_wr_ok = wrreq && !w_full;
  assign w_rd_ok = rdreq && !w_empty;

  always_ff @(posedge clock) begin
    if (w_wr_ok) r_mem[r_wp[ADDR_W-1:0]] <= data;
  end

  // A set event in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clock or negedge sclr) begin
    if (!sclr) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (w_wr_ok) r_wp <= r_wp + 1'b1;
      if (w_rd_ok) r_rp <= r_rp + 1'b1;
      r_ovf <= (wrreq && w_full)  || (r_ovf && !err_clr);
      r_udf <= (rdreq && w_empty) || (r_udf && !err_clr);
    end
  end

`ifdef FIFO_PARAM_REGOUT_EN
  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clock or negedge sclr) begin
    if (!sclr) begin
      r_q <= '0;
    end else if (w_rd_ok) begin
      r_q <= r_mem[r_rp[ADDR_W-1:0]];
    end
  end

  assign q = r_q;
`else
  assign q = r_mem[r_rp[ADDR_W-1:0]];
`endif

  assign full         = w_full;
  assign empty        = w_empty;
  assign usedw        = w_usedw;
  assign almost_full  = (w_usedw >= AF_L);
  assign almost_empty = (w_usedw <= AE_L);
  assign overflow     = r_ovf;
  assign underflow    = r_udf;

endmodule

// File: tb/tb_fifo_param.sv
// Directed self-checking bench for fifo_param at default parameters (WIDTH=8, ADDR_W=4),
// covering show-ahead and FIFO_PARAM_REGOUT_EN read timing.
module tb_fifo_param;

  logic       clock;
  logic       sclr;
  logic       wrreq;
  logic [7:0] data;
  logic       rdreq;
  logic [7:0] q;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] usedw;
  logic       overflow;
  logic       underflow;
  logic       err_clr;

  int n_cmp = 0;
  int n_err = 0;

  fifo_param #(.WIDTH(8), .ADDR_W(4), .AF_LEVEL(12), .AE_LEVEL(2)) dut (
    .clock       (clock),
    .sclr        (sclr),
    .wrreq       (wrreq),
    .data        (data),
    .rdreq       (rdreq),
    .q           (q),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .usedw       (usedw),
    .overflow    (overflow),
    .underflow   (underflow),
    .err_clr     (err_clr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  // One clock step; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic reset_fifo();
    wrreq = 1'b0; rdreq = 1'b0; err_clr = 1'b0; data = 8'h00;
    sclr = 1'b0;
    #2;
    sclr = 1'b1;
  endtask

  task automatic push(input logic [7:0] d);
    wrreq = 1'b1; data = d;
    cyc();
    wrreq = 1'b0;
  endtask

  task automatic pop(output logic [7:0] got);
`ifdef FIFO_PARAM_REGOUT_EN
    rdreq = 1'b1;
    cyc();
    rdreq = 1'b0;
    got = q;
`else
    got = q;
    rdreq = 1'b1;
    cyc();
    rdreq = 1'b0;
`endif
  endtask

  task automatic test_reset();
    wrreq = 1'b0; rdreq = 1'b0; err_clr = 1'b0; data = 8'h00;
    sclr = 1'b0;
    #1;
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b want 1", empty); end
    n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", full); end
    n_cmp++; if (usedw !== 5'd0) begin n_err++; $display("FAIL reset_usedw: got %0d want 0", usedw); end
    n_cmp++; if (almost_empty !== 1'b1) begin n_err++; $display("FAIL reset_ae: got %b want 1", almost_empty); end
    n_cmp++; if (almost_full !== 1'b0) begin n_err++; $display("FAIL reset_af: got %b want 0", almost_full); end
    n_cmp++; if ({overflow, underflow} !== 2'b00) begin n_err++; $display("FAIL reset_flags: got %b want 00", {overflow, underflow}); end
`ifdef FIFO_PARAM_REGOUT_EN
    n_cmp++; if (q !== 8'h00) begin n_err++; $display("FAIL reset_q: got %h want 00", q); end
`endif
    cyc();
    sclr = 1'b1;
    cyc();
  endtask

  task automatic test_fill_drain();
    logic [7:0] got;
    reset_fifo();
    for (int i = 1; i <= 16; i++) begin
      push(8'(i));
      n_cmp++; if (usedw !== 5'(i)) begin n_err++; $display("FAIL fill_usedw[%0d]: got %0d want %0d", i, usedw, i); end
      n_cmp++; if (almost_full !== (i >= 12)) begin n_err++; $display("FAIL fill_af[%0d]: got %b want %b", i, almost_full, (i >= 12)); end
      n_cmp++; if (almost_empty !== (i <= 2)) begin n_err++; $display("FAIL fill_ae[%0d]: got %b want %b", i, almost_empty, (i <= 2)); end
      n_cmp++; if (full !== (i == 16)) begin n_err++; $display("FAIL fill_full[%0d]: got %b want %b", i, full, (i == 16)); end
      n_cmp++; if (empty !== 1'b0) begin n_err++; $display("FAIL fill_empty[%0d]: got %b want 0", i, empty); end
    end
    for (int i = 1; i <= 16; i++) begin
      pop(got);
      n_cmp++; if (got !== 8'(i)) begin n_err++; $display("FAIL drain_q[%0d]: got %h want %h", i, got, 8'(i)); end
      n_cmp++; if (usedw !== 5'(16 - i)) begin n_err++; $display("FAIL drain_usedw[%0d]: got %0d want %0d", i, usedw, 16 - i); end
    end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL drain_empty: got %b want 1", empty); end
    n_cmp++; if ({overflow, underflow} !== 2'b00) begin n_err++; $display("FAIL drain_flags: got %b want 00", {overflow, underflow}); end
  endtask

  task automatic test_overflow();
    logic [7:0] got;
    reset_fifo();
    for (int i = 1; i <= 16; i++) push(8'(8'h40 + i));
    push(8'hAA);
    n_cmp++; if (usedw !== 5'd16) begin n_err++; $display("FAIL ovf_usedw: got %0d want 16", usedw); end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    n_cmp++; if (underflow !== 1'b0) begin n_err++; $display("FAIL ovf_udf: got %b want 0", underflow); end
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clr: got %b want 0", overflow); end
    for (int i = 1; i <= 16; i++) begin
      pop(got);
      n_cmp++; if (got !== 8'(8'h40 + i)) begin n_err++; $display("FAIL ovf_data[%0d]: got %h want %h", i, got, 8'(8'h40 + i)); end
    end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL ovf_drop: empty got %b want 1", empty); end
  endtask

  task automatic test_underflow();
    logic [7:0] got;
    reset_fifo();
    rdreq = 1'b1;
    cyc();
    rdreq = 1'b0;
    n_cmp++; if (underflow !== 1'b1) begin n_err++; $display("FAIL udf_flag: got %b want 1", underflow); end
    n_cmp++; if (usedw !== 5'd0) begin n_err++; $display("FAIL udf_usedw: got %0d want 0", usedw); end
    wrreq = 1'b1; rdreq = 1'b1; data = 8'h55;
    cyc();
    wrreq = 1'b0; rdreq = 1'b0;
    n_cmp++; if (usedw !== 5'd1) begin n_err++; $display("FAIL udf_rw_usedw: got %0d want 1", usedw); end
    n_cmp++; if (underflow !== 1'b1) begin n_err++; $display("FAIL udf_rw_flag: got %b want 1", underflow); end
`ifdef FIFO_PARAM_REGOUT_EN
    n_cmp++; if (q !== 8'h00) begin n_err++; $display("FAIL udf_q_hold: got %h want 00", q); end
`endif
    pop(got);
    n_cmp++; if (got !== 8'h55) begin n_err++; $display("FAIL udf_rw_q: got %h want 55", got); end
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    n_cmp++; if (underflow !== 1'b0) begin n_err++; $display("FAIL udf_clr: got %b want 0", underflow); end
    // Clear and set in the same cycle: set wins.
    err_clr = 1'b1; rdreq = 1'b1;
    cyc();
    err_clr = 1'b0; rdreq = 1'b0;
    n_cmp++; if (underflow !== 1'b1) begin n_err++; $display("FAIL udf_set_wins: got %b want 1", underflow); end
  endtask

  task automatic test_full_rdwr();
    logic [7:0] got;
    reset_fifo();
    for (int i = 1; i <= 16; i++) push(8'(i));
    wrreq = 1'b1; rdreq = 1'b1; data = 8'hBB;
`ifndef FIFO_PARAM_REGOUT_EN
    got = q;
`endif
    cyc();
    wrreq = 1'b0; rdreq = 1'b0;
`ifdef FIFO_PARAM_REGOUT_EN
    got = q;
`endif
    n_cmp++; if (got !== 8'h01) begin n_err++; $display("FAIL frw_head: got %h want 01", got); end
    n_cmp++; if (usedw !== 5'd15) begin n_err++; $display("FAIL frw_usedw: got %0d want 15", usedw); end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL frw_ovf: got %b want 1", overflow); end
    for (int i = 2; i <= 16; i++) begin
      pop(got);
      n_cmp++; if (got !== 8'(i)) begin n_err++; $display("FAIL frw_data[%0d]: got %h want %h", i, got, 8'(i)); end
    end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL frw_empty: got %b want 1", empty); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] got;
    logic [7:0] wv;
    logic [7:0] rv;
    int bad_q;
    int bad_u;
    reset_fifo();
    wv = 8'h20; rv = 8'h20; bad_q = 0; bad_u = 0;
    for (int i = 0; i < 5; i++) begin push(wv); wv++; end
    for (int i = 0; i < 40; i++) begin
      wrreq = 1'b1; rdreq = 1'b1; data = wv;
`ifndef FIFO_PARAM_REGOUT_EN
      got = q;
`endif
      cyc();
`ifdef FIFO_PARAM_REGOUT_EN
      got = q;
`endif
      n_cmp++; if (got !== rv) begin n_err++; bad_q++; if (bad_q < 4) $display("FAIL b2b_q[%0d]: got %h want %h", i, got, rv); end
      n_cmp++; if (usedw !== 5'd5) begin n_err++; bad_u++; if (bad_u < 4) $display("FAIL b2b_usedw[%0d]: got %0d want 5", i, usedw); end
      wv++; rv++;
    end
    wrreq = 1'b0; rdreq = 1'b0;
    n_cmp++; if ({overflow, underflow} !== 2'b00) begin n_err++; $display("FAIL b2b_flags: got %b want 00", {overflow, underflow}); end
    for (int i = 0; i < 5; i++) begin
      pop(got);
      n_cmp++; if (got !== rv) begin n_err++; $display("FAIL b2b_tail[%0d]: got %h want %h", i, got, rv); end
      rv++;
    end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL b2b_empty: got %b want 1", empty); end
  endtask

  task automatic test_async_reset();
    logic [7:0] got;
    reset_fifo();
    rdreq = 1'b1;
    cyc();
    rdreq = 1'b0;
    for (int i = 0; i < 9; i++) push(8'(8'h90 + i));
    n_cmp++; if (usedw !== 5'd9) begin n_err++; $display("FAIL ar_pre_usedw: got %0d want 9", usedw); end
    n_cmp++; if (underflow !== 1'b1) begin n_err++; $display("FAIL ar_pre_udf: got %b want 1", underflow); end
    wrreq = 1'b1; data = 8'hEE;
    #2;
    sclr = 1'b0;
    #1;
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL ar_empty: got %b want 1", empty); end
    n_cmp++; if (usedw !== 5'd0) begin n_err++; $display("FAIL ar_usedw: got %0d want 0", usedw); end
    n_cmp++; if (almost_empty !== 1'b1) begin n_err++; $display("FAIL ar_ae: got %b want 1", almost_empty); end
    n_cmp++; if ({full, almost_full} !== 2'b00) begin n_err++; $display("FAIL ar_full: got %b want 00", {full, almost_full}); end
    n_cmp++; if ({overflow, underflow} !== 2'b00) begin n_err++; $display("FAIL ar_flags: got %b want 00", {overflow, underflow}); end
    wrreq = 1'b0;
    cyc();
    n_cmp++; if (usedw !== 5'd0) begin n_err++; $display("FAIL ar_hold_usedw: got %0d want 0", usedw); end
    #2;
    sclr = 1'b1;
    push(8'h3C);
    n_cmp++; if (usedw !== 5'd1) begin n_err++; $display("FAIL ar_post_usedw: got %0d want 1", usedw); end
    pop(got);
    n_cmp++; if (got !== 8'h3C) begin n_err++; $display("FAIL ar_post_q: got %h want 3c", got); end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL ar_post_empty: got %b want 1", empty); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_full_rdwr();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
